// File: rtl/tdi_host.sv
// tdi_host: host-side master for the two-wire debug interface.
// Serializes one command (opcode, optional address/data) LSB first on SCK/SDI,
// inserts an SCK-high gap after every transmit phase, collects the target's
// response bits from SDO and returns the word through a valid/ready port.
module tdi_host #(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 48
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        SCK,
  output logic        SDI,
  input  logic        SDO,
  input  logic        SDOE
);

  localparam logic [7:0] OP_PING   = 8'hA1;
  localparam logic [7:0] OP_CYCLES = 8'hA2;
  localparam logic [7:0] OP_HALT   = 8'hA4;
  localparam logic [7:0] OP_RESUME = 8'hA5;
  localparam logic [7:0] OP_RESET  = 8'hA6;
  localparam logic [7:0] OP_READ   = 8'hA8;
  localparam logic [7:0] OP_WRITE  = 8'hA9;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [9:0] GAP_LAST  = 10'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_GAP,
    ST_RX,
    ST_RESP
  } state_t;

  // Opcodes the target understands; anything else is answered locally.
  function automatic logic op_supported(input logic [7:0] op);
    logic ok;
    case (op)
      OP_PING, OP_CYCLES, OP_HALT, OP_RESUME,
      OP_RESET, OP_READ, OP_WRITE: ok = 1'b1;
      default:                     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Index of the last response bit for opcodes that have a receive phase.
  function automatic logic [5:0] rx_last_of(input logic [7:0] op);
    logic [5:0] last;
    case (op)
      OP_PING, OP_HALT, OP_RESUME, OP_RESET: last = 6'd7;
      OP_CYCLES:                             last = 6'd15;
      default:                               last = 6'd31;
    endcase
    return last;
  endfunction

  // Fixed acknowledge values for the control opcodes.
  function automatic logic rsp_check_fail(input logic [7:0] op, input logic [31:0] data);
    logic fail;
    case (op)
      OP_PING:                      fail = (data != 32'h0000_0081);
      OP_HALT, OP_RESUME, OP_RESET: fail = (data != 32'h0000_0001);
      default:                      fail = 1'b0;
    endcase
    return fail;
  endfunction

  state_t      state_r;
  logic [7:0]  op_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  phase_r;
  logic [7:0]  half_cnt_r;
  logic [5:0]  bit_cnt_r;
  logic [5:0]  bit_last_r;
  logic [9:0]  gap_cnt_r;
  logic [31:0] tx_shift_r;
  logic [31:0] rx_data_r;
  logic        rx_err_r;
  logic        sck_r;
  logic        sdi_r;
  logic        cmd_ready_r;
  logic        busy_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_data_r;
  logic        rsp_err_r;
  logic        sdo_meta_r;
  logic        sdo_sync_r;
  logic        sdoe_meta_r;
  logic        sdoe_sync_r;

  logic        half_end_s;
  logic        last_bit_s;
  logic        gap_end_s;
  logic [31:0] rx_word_s;
  state_t      gap_next_s;
  logic [31:0] gap_word_s;

  // Two-flop synchronizers for the asynchronous target-driven lines.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sdo_meta_r  <= 1'b0;
      sdo_sync_r  <= 1'b0;
      sdoe_meta_r <= 1'b0;
      sdoe_sync_r <= 1'b0;
    end else begin
      sdo_meta_r  <= SDO;
      sdo_sync_r  <= sdo_meta_r;
      sdoe_meta_r <= SDOE;
      sdoe_sync_r <= sdoe_meta_r;
    end
  end

  // Phase-end strobes and the response word including the bit sampled now.
  always_comb begin
    half_end_s = (half_cnt_r == HALF_LAST);
    last_bit_s = (bit_cnt_r == bit_last_r);
    gap_end_s  = (gap_cnt_r == GAP_LAST);
    rx_word_s  = rx_data_r | (32'(sdo_sync_r) << bit_cnt_r[4:0]);
  end

  // Phase that follows a gap: address, data, receive, or straight to response.
  always_comb begin
    gap_next_s = ST_RESP;
    gap_word_s = 32'd0;
    case (phase_r)
      2'd0: begin
        if (op_r == OP_READ || op_r == OP_WRITE) begin
          gap_next_s = ST_TX;
          gap_word_s = addr_r;
        end else begin
          gap_next_s = ST_RX;
          gap_word_s = 32'd0;
        end
      end
      2'd1: begin
        if (op_r == OP_WRITE) begin
          gap_next_s = ST_TX;
          gap_word_s = wdata_r;
        end else begin
          gap_next_s = ST_RX;
          gap_word_s = 32'd0;
        end
      end
      default: begin
        gap_next_s = ST_RESP;
        gap_word_s = 32'd0;
      end
    endcase
  end

  // Transaction FSM: drives the wire, counts bits/gaps, builds the response.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= ST_IDLE;
      op_r        <= 8'd0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      phase_r     <= 2'd0;
      half_cnt_r  <= 8'd0;
      bit_cnt_r   <= 6'd0;
      bit_last_r  <= 6'd0;
      gap_cnt_r   <= 10'd0;
      tx_shift_r  <= 32'd0;
      rx_data_r   <= 32'd0;
      rx_err_r    <= 1'b0;
      sck_r       <= 1'b1;
      sdi_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r        <= cmd_op;
            addr_r      <= cmd_addr;
            wdata_r     <= cmd_wdata;
            busy_r      <= 1'b1;
            cmd_ready_r <= 1'b0;
            phase_r     <= 2'd0;
            half_cnt_r  <= 8'd0;
            bit_cnt_r   <= 6'd0;
            gap_cnt_r   <= 10'd0;
            rx_data_r   <= 32'd0;
            rx_err_r    <= 1'b0;
            if (op_supported(cmd_op)) begin
              state_r    <= ST_TX;
              sck_r      <= 1'b1;
              sdi_r      <= cmd_op[0];
              tx_shift_r <= {25'd0, cmd_op[7:1]};
              bit_last_r <= 6'd7;
            end else begin
              // Unknown opcode: no wire activity, error response next cycle.
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= 32'd0;
              rsp_err_r   <= 1'b1;
            end
          end
        end

        ST_TX: begin
          if (half_end_s) begin
            half_cnt_r <= 8'd0;
            if (sck_r) begin
              sck_r <= 1'b0;
            end else begin
              sck_r <= 1'b1;
              if (last_bit_s) begin
                state_r   <= ST_GAP;
                gap_cnt_r <= 10'd0;
                bit_cnt_r <= 6'd0;
                sdi_r     <= 1'b0;
              end else begin
                bit_cnt_r  <= bit_cnt_r + 6'd1;
                sdi_r      <= tx_shift_r[0];
                tx_shift_r <= {1'b0, tx_shift_r[31:1]};
              end
            end
          end else begin
            half_cnt_r <= half_cnt_r + 8'd1;
          end
        end

        ST_GAP: begin
          if (gap_end_s) begin
            gap_cnt_r  <= 10'd0;
            half_cnt_r <= 8'd0;
            bit_cnt_r  <= 6'd0;
            case (gap_next_s)
              ST_TX: begin
                state_r    <= ST_TX;
                phase_r    <= phase_r + 2'd1;
                sdi_r      <= gap_word_s[0];
                tx_shift_r <= {1'b0, gap_word_s[31:1]};
                bit_last_r <= 6'd31;
              end
              ST_RX: begin
                state_r    <= ST_RX;
                bit_last_r <= rx_last_of(op_r);
              end
              default: begin
                // WRITE has no receive phase: empty, error-free response.
                state_r     <= ST_RESP;
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= 32'd0;
                rsp_err_r   <= 1'b0;
              end
            endcase
          end else begin
            gap_cnt_r <= gap_cnt_r + 10'd1;
          end
        end

        ST_RX: begin
          if (half_end_s) begin
            half_cnt_r <= 8'd0;
            if (sck_r) begin
              sck_r <= 1'b0;
            end else begin
              // Rising-edge cycle: sample data and output-enable together.
              sck_r     <= 1'b1;
              rx_data_r <= rx_word_s;
              if (!sdoe_sync_r) begin
                rx_err_r <= 1'b1;
              end
              if (last_bit_s) begin
                state_r     <= ST_RESP;
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= rx_word_s;
                rsp_err_r   <= rx_err_r | ~sdoe_sync_r | rsp_check_fail(op_r, rx_word_s);
              end else begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
              end
            end
          end else begin
            half_cnt_r <= half_cnt_r + 8'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          sck_r       <= 1'b1;
          sdi_r       <= 1'b0;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign SCK       = sck_r;
  assign SDI       = sdi_r;

endmodule

// File: tb/tb_tdi_host.sv
// Bench for tdi_host: a target model decodes the host's wire traffic and
// answers on SDO; a response model derived from the protocol rules predicts
// data, error flag, latency and SCK edge counts for each command.
module tb_tdi_host;

  localparam int CLK_DIV    = 8;
  localparam int GAP_CYCLES = 48;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_op = 8'h00;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        SCK;
  logic        SDI;
  logic        SDO = 1'b0;
  logic        SDOE = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;

  // target-model configuration and captures
  logic [31:0] tgt_word = 32'h0;
  logic        tgt_sdoe_zero = 1'b0;
  logic [7:0]  cap_op = 8'h0;
  logic [31:0] cap_addr = 32'h0;
  logic [31:0] cap_data = 32'h0;
  int          fall_n = 0;
  int          rise_cnt = 0;
  int          hi_run = 0;
  int          lo_run = 0;
  logic        prev_sck = 1'b1;

  // response-model expectations
  logic [71:0] exp_tx = 72'h0;
  int          exp_tx_n = 0;
  logic [31:0] exp_data = 32'h0;
  logic        exp_err = 1'b0;
  int          exp_lat = 0;

  tdi_host #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .SCK(SCK), .SDI(SDI), .SDO(SDO), .SDOE(SDOE)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int tx_bits_of(input logic [7:0] op);
    case (op)
      8'hA1, 8'hA2, 8'hA4, 8'hA5, 8'hA6: return 8;
      8'hA8:                             return 40;
      8'hA9:                             return 72;
      default:                           return 0;
    endcase
  endfunction

  function automatic int rx_bits_of(input logic [7:0] op);
    case (op)
      8'hA1, 8'hA4, 8'hA5, 8'hA6: return 8;
      8'hA2:                      return 16;
      8'hA8:                      return 32;
      default:                    return 0;
    endcase
  endfunction

  // Predict everything the host must show for one command.
  task automatic set_model(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word,
                           input logic sdoe_zero);
    int tx_n;
    int rx_n;
    int gaps;
    tx_n = tx_bits_of(op);
    rx_n = rx_bits_of(op);
    exp_tx   = {wdata, addr, op};
    exp_tx_n = tx_n;
    if (rx_n == 0)       exp_data = 32'h0;
    else if (rx_n == 32) exp_data = word;
    else                 exp_data = word & ((32'd1 << rx_n) - 32'd1);
    exp_err = (tx_n == 0) || (rx_n > 0 && sdoe_zero)
           || (op == 8'hA1 && exp_data != 32'h81)
           || ((op == 8'hA4 || op == 8'hA5 || op == 8'hA6) && exp_data != 32'h01);
    gaps = (tx_n == 8) ? 1 : (tx_n == 40) ? 2 : 3;
    exp_lat = (tx_n == 0) ? 0 : 2 * CLK_DIV * (tx_n + rx_n) + GAP_CYCLES * gaps;
    tgt_word      = word;
    tgt_sdoe_zero = sdoe_zero;
  endtask

  // Per-cycle target model and output comparison.
  task automatic mon_loop();
    int n;
    int tot;
    forever begin
      @(negedge HCLK);
      if (!busy) begin
        fall_n = 0; rise_cnt = 0; hi_run = 0; lo_run = 0;
        cap_op = 8'h0; cap_addr = 32'h0; cap_data = 32'h0;
        SDO = 1'b0; SDOE = 1'b1;
        check("idle_sck", {31'd0, SCK}, 32'd1);
        check("idle_sdi", {31'd0, SDI}, 32'd0);
      end else begin
        if (SCK) begin
          if (!prev_sck) begin
            check("low_half_len", lo_run, CLK_DIV);
            rise_cnt++;
          end
          hi_run++;
          lo_run = 0;
        end else begin
          if (prev_sck) begin
            n = fall_n;
            if (n > 0)
              check("high_half_len", hi_run,
                    (n == 8 || n == 40) ? CLK_DIV + GAP_CYCLES : CLK_DIV);
            if (n < exp_tx_n) check("sdi_bit", {31'd0, SDI}, {31'd0, exp_tx[n]});
            else              check("sdi_rx_zero", {31'd0, SDI}, 32'd0);
            tot = tx_bits_of(cap_op);
            if (n < 8) cap_op[n] = SDI;
            else if (n < tot) begin
              if (n < 40) cap_addr[n-8] = SDI;
              else        cap_data[n-40] = SDI;
            end else begin
              if (n - tot < 32) SDO = tgt_word[n-tot];
              SDOE = !tgt_sdoe_zero;
            end
            fall_n++;
          end
          lo_run++;
          hi_run = 0;
        end
        if (rsp_valid) begin
          check("rsp_data_model", rsp_data, exp_data);
          check("rsp_err_model", {31'd0, rsp_err}, {31'd0, exp_err});
          check("cmd_ready_in_resp", {31'd0, cmd_ready}, 32'd0);
        end
      end
      prev_sck = SCK;
    end
  endtask

  task automatic start_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge HCLK);
    check("cmd_ready_before", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("cmd_ready_after_accept", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] word, input logic sdoe_zero, input int stall,
                         input logic [31:0] lit_data, input logic lit_err, input int lit_rises);
    int lat;
    set_model(op, addr, wdata, word, sdoe_zero);
    start_cmd(op, addr, wdata);
    lat = 0;
    while (!rsp_valid && lat < 4000) begin
      @(posedge HCLK); #1;
      lat++;
    end
    check("rsp_latency", lat, exp_lat);
    @(negedge HCLK); #1;
    check("rsp_data", rsp_data, lit_data);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, lit_err});
    check("sck_rises", rise_cnt, lit_rises);
    if (exp_tx_n > 0)   check("tgt_op", {24'd0, cap_op}, {24'd0, op});
    if (exp_tx_n >= 40) check("tgt_addr", cap_addr, addr);
    if (exp_tx_n == 72) check("tgt_data", cap_data, wdata);
    if (stall > 0) begin
      cmd_valid = 1'b1; cmd_op = 8'hA1;
      repeat (stall) @(negedge HCLK);
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_data", rsp_data, lit_data);
      check("stall_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge HCLK);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge HCLK); #1;
    rsp_ready = 1'b0;
    check("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_hs_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_hs_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge HCLK);
  endtask

  initial begin
    fork
      mon_loop();
    join_none

    // reset values
    repeat (3) @(posedge HCLK); #1;
    check("rst_sck", {31'd0, SCK}, 32'd1);
    check("rst_sdi", {31'd0, SDI}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge HCLK); HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);

    //        op     addr          wdata         word          oe0   stall data          err   rises
    run_cmd(8'hA1, 32'h0,        32'h0,        32'h81,       1'b0, 0,  32'h81,       1'b0, 16);
    run_cmd(8'hA1, 32'h0,        32'h0,        32'h80,       1'b0, 0,  32'h80,       1'b1, 16);
    run_cmd(8'hA9, 32'hABCD1234, 32'hDEAD5555, 32'h0,        1'b0, 0,  32'h0,        1'b0, 72);
    run_cmd(8'hA8, 32'h20000010, 32'h0,        32'hCAFEF00D, 1'b0, 20, 32'hCAFEF00D, 1'b0, 72);
    run_cmd(8'hA2, 32'h0,        32'h0,        32'h0000BEEF, 1'b1, 0,  32'h0000BEEF, 1'b1, 24);
    run_cmd(8'hA2, 32'h0,        32'h0,        32'h12345678, 1'b0, 0,  32'h00005678, 1'b0, 24);
    run_cmd(8'h55, 32'h0,        32'h0,        32'h0,        1'b0, 0,  32'h0,        1'b1, 0);
    run_cmd(8'hA4, 32'h0,        32'h0,        32'h01,       1'b0, 0,  32'h01,       1'b0, 16);
    run_cmd(8'hA5, 32'h0,        32'h0,        32'h03,       1'b0, 0,  32'h03,       1'b1, 16);
    run_cmd(8'hA6, 32'h0,        32'h0,        32'h01,       1'b0, 0,  32'h01,       1'b0, 16);

    // reset during the address phase of a READ (low half of address bit 4)
    set_model(8'hA8, 32'h20000010, 32'h0, 32'h12345678, 1'b0);
    start_cmd(8'hA8, 32'h20000010, 32'h0);
    repeat (251) @(posedge HCLK); #2;
    check("pre_rst_sck_low", {31'd0, SCK}, 32'd0);
    check("pre_rst_sdi_one", {31'd0, SDI}, 32'd1);
    HRESETn = 1'b0;
    #1;
    check("mid_rst_sck", {31'd0, SCK}, 32'd1);
    check("mid_rst_sdi", {31'd0, SDI}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (3) @(posedge HCLK);
    @(negedge HCLK); HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    run_cmd(8'hA1, 32'h0, 32'h0, 32'h81, 1'b0, 0, 32'h81, 1'b0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
